// File: rtl/sqrt_pkg.sv
// Constants shared by the sqrt table writer and the magnitude stage that reads the table,
// so both sides derive the same address mapping and saturation value.
package sqrt_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SHIFT_DEF      = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_WRITE,
        S_DONE
    } state_e;

    // Reader forms its address as (gx^2 + gy^2) >> shift.
    function automatic int addr_width(input int data_width, input int shift);
        return 2 * data_width + 1 - shift;
    endfunction

    function automatic int sat_max(input int data_width);
        return (1 << data_width) - 1;
    endfunction

endpackage

// File: rtl/sqrt_table_writer_if.sv
// Start/status handshake plus the table RAM write port.
interface sqrt_table_writer_if #(
    parameter int DATA_WIDTH = sqrt_pkg::DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = sqrt_pkg::addr_width(sqrt_pkg::DATA_WIDTH_DEF, sqrt_pkg::SHIFT_DEF)
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    modport master (input start, output busy, done, mem_we, mem_addr, mem_din);
    modport slave  (output start, input busy, done, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/sqrt_iter.sv
// Bit-serial restoring square root, one root bit per cycle, MSB first.
// root/valid are the post-step values: valid is high in the cycle whose edge completes the last step.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [2*DATA_WIDTH:0] radicand,
    output logic [DATA_WIDTH:0]   root,
    output logic                  valid
);
    localparam int ROOT_W = DATA_WIDTH + 1;
    localparam int PAIR_W = 2 * ROOT_W;
    localparam int REM_W  = DATA_WIDTH + 3;
    localparam int CNT_W  = $clog2(ROOT_W + 1);

    logic [PAIR_W-1:0] rad_q, rad_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [REM_W+1:0]  rem_sh, trial;

    always_comb begin
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        valid  = 1'b0;
        rem_sh = {rem_q, rad_q[PAIR_W-1 -: 2]};
        trial  = (REM_W+2)'({root_q, 2'b01});
        if (load) begin
            // Zero-extend to an even width so the radicand splits into whole bit pairs.
            rad_d  = PAIR_W'(radicand);
            rem_d  = '0;
            root_d = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            rad_d = rad_q << 2;
            if (rem_sh >= trial) begin
                rem_d  = REM_W'(rem_sh - trial);
                root_d = {root_q[ROOT_W-2:0], 1'b1};
            end else begin
                rem_d  = REM_W'(rem_sh);
                root_d = {root_q[ROOT_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ROOT_W - 1)) begin
                run_d = 1'b0;
                valid = 1'b1;
            end
        end
    end

    assign root = root_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/sqrt_table_writer.sv
// Walks every table address once per start, writing the saturated floor-sqrt of each
// bin-midpoint radicand; done pulses after the last entry.
module sqrt_table_writer
    import sqrt_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int ADDR_WIDTH = addr_width(DATA_WIDTH, SHIFT)
) (
    input logic                 clk,
    input logic                 rst,
    sqrt_table_writer_if.master bus
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;

    logic                  iter_load;
    logic                  iter_valid;
    logic [DATA_WIDTH:0]   iter_root;
    logic [2*DATA_WIDTH:0] radicand;

    // Bin midpoint: address in the high bits, a single one just below the shifted-out field.
    assign radicand = {addr_q, 1'b1, {(SHIFT-1){1'b0}}};

    sqrt_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (iter_load),
        .radicand (radicand),
        .root     (iter_root),
        .valid    (iter_valid)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        iter_load  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_LOAD;
                addr_d  = '0;
                busy_d  = 1'b1;
            end
            S_LOAD: begin
                iter_load = 1'b1;
                state_d   = S_ITER;
            end
            S_ITER: if (iter_valid) begin
                state_d    = S_WRITE;
                mem_we_d   = 1'b1;
                mem_addr_d = addr_q;
                mem_din_d  = iter_root[DATA_WIDTH] ? DATA_WIDTH'(sat_max(DATA_WIDTH))
                                                   : iter_root[DATA_WIDTH-1:0];
            end
            S_WRITE: if (&addr_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = S_LOAD;
                addr_d  = addr_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_sqrt_table_writer.sv
// Scoreboard bench for sqrt_table_writer: stimulus queues expected writes, a negedge monitor checks them.
module tb_sqrt_table_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sqrt_table_writer_if bus ();

    sqrt_table_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    // floor(sqrt(8192*a + 4096)) saturated at 255
    localparam logic [7:0] EXP_TBL [16] = '{
        8'd64,  8'd110, 8'd143, 8'd169, 8'd192, 8'd212, 8'd230, 8'd247,
        8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255
    };

    wr_t  exp_q [$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   first_we = -1;
    logic prev_we  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        for (int a = 0; a < 16; a++) exp_q.push_back(wr_t'{addr: 4'(a), data: EXP_TBL[a]});
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.done === 1'b1) break;
        end
        chk(nm, int'(bus.done), 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},     int'(bus.busy),     0);
        chk({tag, "_done"},     int'(bus.done),     0);
        chk({tag, "_mem_we"},   int'(bus.mem_we),   0);
        chk({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
        chk({tag, "_mem_din"},  int'(bus.mem_din),  0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: values visible after edge k are what edge k+1 samples.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (bus.mem_we === 1'b1) begin
            wr_cnt++;
            if (first_we < 0) first_we = cyc + 1;
            chk("we_back_to_back", int'(prev_we), 0);
            chk("write_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(bus.mem_addr), int'(e.addr));
                chk("wr_data", int'(bus.mem_din), int'(e.data));
            end
        end
        if (bus.done === 1'b1) done_cnt++;
        prev_we = bus.mem_we;
    end

    initial begin
        int n_start, w0, d0;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Single run: latency, order, values
        push_run();
        first_we  = -1;
        w0        = wr_cnt;
        bus.start = 1'b1;
        n_start   = cyc + 1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
        wait_done("run1_done");
        chk("done_latency", cyc + 1 - n_start, 177);
        chk("first_we_latency", first_we - n_start, 11);
        chk("run1_writes", wr_cnt - w0, 16);
        chk("run1_queue_empty", exp_q.size(), 0);
        step();
        chk("busy_after_done", int'(bus.busy), 0);
        chk("done_one_cycle", int'(bus.done), 0);

        // start held for the whole run, dropped before IDLE resamples it
        push_run();
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.start = 1'b1;
        wait_done("held_done");
        bus.start = 1'b0;
        repeat (40) step();
        chk("held_writes", wr_cnt - w0, 16);
        chk("held_done_count", done_cnt - d0, 1);
        chk("held_busy_idle", int'(bus.busy), 0);
        chk("held_queue_empty", exp_q.size(), 0);

        // Reset after the 5th write
        push_run();
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt - w0 >= 5) break;
            step();
        end
        chk("five_writes_seen", wr_cnt - w0, 5);
        rst = 1'b1;
        step();
        chk_idle_outputs("midrun_rst");
        exp_q.delete();
        rst = 1'b0;
        repeat (30) step();
        chk("post_rst_writes", wr_cnt - w0, 5);
        chk("post_rst_no_done", done_cnt - d0, 0);

        push_run();
        w0 = wr_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("rebuild_done");
        chk("rebuild_writes", wr_cnt - w0, 16);
        chk("rebuild_queue_empty", exp_q.size(), 0);
        step();

        // Back-to-back: start raised in the DONE cycle, sampled in the following IDLE
        push_run();
        w0 = wr_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done("b2b_run1_done");
        push_run();
        bus.start = 1'b1;
        step();
        chk("b2b_gap_busy_low", int'(bus.busy), 0);
        step();
        bus.start = 1'b0;
        chk("b2b_restart_busy", int'(bus.busy), 1);
        wait_done("b2b_run2_done");
        chk("b2b_writes", wr_cnt - w0, 32);
        chk("b2b_queue_empty", exp_q.size(), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
